// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM controller between two requesters.
// Holds the controller command stable while busy and inserts the write-cycle gap after writes.
module eeprom_arbiter #(
  parameter int WR_WAIT = 250000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       req0,
  input  logic       wr0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       wr1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata1,
  output logic       busy,
  output logic [1:0] Start_Sig,
  output logic [7:0] Addr_Sig,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  input  logic       Done_Sig
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE, WAIT} state_t;

  localparam logic [19:0] WAIT_LAST = 20'(WR_WAIT - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  start_q, start_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        busy_q, busy_d;

  // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
  logic pick1;
  logic sel_wr;
  assign pick1  = req1 & (~req0 | ~last_q);
  assign sel_wr = pick1 ? wr1 : wr0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    start_d  = start_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pick1;
          last_d  = pick1;
          wr_d    = sel_wr;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          start_d = sel_wr ? 2'b01 : 2'b10;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (Done_Sig) begin
          start_d = 2'b00;
          state_d = RELEASE;
          if (gnt_q) begin
            ack1_d = 1'b1;
            if (!wr_q) rdata1_d = RdData;
          end else begin
            ack0_d = 1'b1;
            if (!wr_q) rdata0_d = RdData;
          end
        end
      end
      RELEASE: begin
        cnt_d   = '0;
        state_d = wr_q ? WAIT : IDLE;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      start_q  <= 2'b00;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      start_q  <= start_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign Start_Sig = start_q;
  assign Addr_Sig  = addr_q;
  assign WrData    = wdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Scoreboard bench for eeprom_arbiter: timeline reference model, behavioural iic_com with
// EEPROM memory, directed scenarios followed by two randomized requesters.
module tb_eeprom_arbiter;
  localparam int WR_WAIT = 16;
  localparam int TMO     = 2000;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [7:0] addr0 = 8'h00, wdata0 = 8'h00, addr1 = 8'h00, wdata1 = 8'h00;
  logic       ack0, ack1, busy;
  logic [7:0] rdata0, rdata1, Addr_Sig, WrData;
  logic [1:0] Start_Sig;
  logic [7:0] RdData = 8'h00;
  logic       Done_Sig = 1'b0;

  eeprom_arbiter #(.WR_WAIT(WR_WAIT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .Start_Sig(Start_Sig), .Addr_Sig(Addr_Sig), .WrData(WrData),
    .RdData(RdData), .Done_Sig(Done_Sig)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    int         port;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } gnt_t;

  typedef struct {
    int cyc;
    int port;
  } ack_t;

  int   checks = 0, failures = 0, cyc = 0;
  gnt_t gq[$];
  ack_t aq[$];
  int   ack_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h cyc=%0d", nm, act, req, cyc);
    end
  endtask

  // Reference model: who is granted, on which cycle, and when the arbiter is free again.
  bit         m_busy = 0;
  int         m_free_at = 0;
  int         m_last = 1;
  gnt_t       m_cur;
  logic [7:0] mmem [256];
  logic [7:0] exp_r0 = 8'h00, exp_r1 = 8'h00;
  bit         exp_busy = 0;

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    forever begin
      @(posedge CLK);
      cyc++;
      if (!RSTn) begin
        m_busy = 0; m_free_at = 0; m_last = 1;
        exp_r0 = 8'h00; exp_r1 = 8'h00; exp_busy = 0;
        gq.delete(); aq.delete();
      end else begin
        if (m_busy) begin
          if (Done_Sig) begin
            ack_t a;
            m_busy = 0;
            if (m_cur.wr) mmem[m_cur.addr] = m_cur.wdata;
            else if (m_cur.port == 0) exp_r0 = mmem[m_cur.addr];
            else exp_r1 = mmem[m_cur.addr];
            a.cyc = cyc; a.port = m_cur.port;
            aq.push_back(a);
            m_free_at = cyc + 2 + (m_cur.wr ? WR_WAIT : 0);
          end
        end else if (cyc >= m_free_at && (req0 || req1)) begin
          m_cur.port  = (req0 && req1) ? (1 - m_last) : (req0 ? 0 : 1);
          m_last      = m_cur.port;
          m_cur.cyc   = cyc;
          m_cur.wr    = (m_cur.port == 0) ? wr0 : wr1;
          m_cur.addr  = (m_cur.port == 0) ? addr0 : addr1;
          m_cur.wdata = (m_cur.port == 0) ? wdata0 : wdata1;
          gq.push_back(m_cur);
          m_busy = 1;
        end
        exp_busy = m_busy || (cyc < m_free_at - 1);
      end
    end
  end

  // Behavioural iic_com: completes each command after a random latency.
  bit         stall = 0, spur_en = 0, served = 0;
  int         lat = 0;
  logic [7:0] imem [256];

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    forever begin
      @(negedge CLK);
      Done_Sig = 1'b0;
      RdData   = 8'($urandom);
      if (!RSTn) begin
        served = 0; lat = 0;
      end else if (Start_Sig != 2'b00) begin
        if (!served && !stall) begin
          if (lat == 0) lat = $urandom_range(2, 7);
          lat--;
          if (lat == 0) begin
            Done_Sig = 1'b1;
            served   = 1;
            if (Start_Sig == 2'b01) imem[Addr_Sig] = WrData;
            else RdData = imem[Addr_Sig];
          end
        end
      end else begin
        served = 0; lat = 0;
        if (spur_en && $urandom_range(0, 5) == 0) Done_Sig = 1'b1;
      end
    end
  end

  // Monitor: compares DUT outputs against the model's expectations.
  logic [1:0] prev_start = 2'b00, hold_start = 2'b00;
  logic [7:0] hold_addr = 8'h00, hold_wd = 8'h00;
  int         gap = 100;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (!RSTn) begin
        prev_start = 2'b00;
        gap = 100;
      end else begin
        chk("busy", busy, exp_busy);
        chk("rdata0", rdata0, exp_r0);
        chk("rdata1", rdata1, exp_r1);
        if (Start_Sig != 2'b00) begin
          if (prev_start == 2'b00) begin
            if (gq.size() == 0) begin
              chk("unexpected_start", Start_Sig, 2'b00);
            end else begin
              gnt_t g;
              g = gq.pop_front();
              chk("grant_cycle", cyc, g.cyc);
              chk("start_code", Start_Sig, g.wr ? 2'b01 : 2'b10);
              chk("addr_sig", Addr_Sig, g.addr);
              chk("wrdata", WrData, g.wdata);
              chk("idle_gap_ge2", gap >= 2, 1);
              hold_start = Start_Sig; hold_addr = Addr_Sig; hold_wd = WrData;
            end
          end else begin
            chk("start_held", Start_Sig, hold_start);
            chk("addr_held", Addr_Sig, hold_addr);
            chk("wrdata_held", WrData, hold_wd);
          end
          gap = 0;
        end else begin
          gap++;
        end
        if (gq.size() > 0 && gq[0].cyc < cyc) begin
          chk("missing_start", Start_Sig, 2'b11);
          void'(gq.pop_front());
        end
        if (ack0 && ack1) chk("dual_ack", 1, 0);
        if (ack0 || ack1) begin
          ack_log.push_back(ack1 ? 1 : 0);
          $display("txn cyc=%0d port=%0d rdata0=%02h rdata1=%02h", cyc, ack1 ? 1 : 0, rdata0, rdata1);
          if (aq.size() == 0) begin
            chk("unexpected_ack", 1, 0);
          end else begin
            ack_t a;
            a = aq.pop_front();
            chk("ack_cycle", cyc, a.cyc);
            chk("ack_port", ack1 ? 1 : 0, a.port);
          end
        end
        if (aq.size() > 0 && aq[0].cyc < cyc) begin
          chk("missing_ack", 0, 1);
          void'(aq.pop_front());
        end
        prev_start = Start_Sig;
      end
    end
  end

  task automatic do_txn(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
    bit got;
    got = 0;
    @(negedge CLK);
    if (p == 0) begin wr0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin wr1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    for (int i = 0; i < TMO; i++) begin
      @(posedge CLK);
      #1;
      if ((p == 0) ? ack0 : ack1) begin got = 1; break; end
    end
    chk("ack_within_timeout", got, 1);
    @(negedge CLK);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge CLK);
      do_txn(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, Start_Sig, 0);
    chk({tag, "_addr"}, Addr_Sig, 0);
    chk({tag, "_wrdata"}, WrData, 0);
    chk({tag, "_ack0"}, ack0, 0);
    chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  bit mut_seen = 0;

  initial begin
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RSTn = 1'b1;

    // Single write, then read back from the other port.
    do_txn(0, 1'b1, 8'h00, 8'h12);
    chk("busy_in_wait", busy, 1);
    do_txn(1, 1'b0, 8'h00, 8'h00);
    chk("readback_rdata1", rdata1, 8'h12);
    repeat (5) @(negedge CLK);
    chk("rdata1_held", rdata1, 8'h12);

    // Request raised a few cycles into WAIT stays pending until WAIT expires.
    do_txn(0, 1'b1, 8'h01, 8'h34);
    repeat (2) @(negedge CLK);
    do_txn(0, 1'b0, 8'h01, 8'h00);
    chk("wait_read_rdata0", rdata0, 8'h34);

    // Granted port's fields change mid-transaction; command must not follow.
    fork
      do_txn(0, 1'b0, 8'h05, 8'h00);
      begin
        for (int i = 0; i < 100 && !mut_seen; i++) begin
          @(negedge CLK);
          if (Start_Sig != 2'b00) begin addr0 = 8'h09; wdata0 = 8'h77; mut_seen = 1; end
        end
        chk("mutator_saw_start", mut_seen, 1);
        for (int i = 0; i < 100; i++) begin
          @(posedge CLK);
          #1;
          if (Start_Sig == 2'b00) break;
          chk("addr_stays_05", Addr_Sig, 8'h05);
        end
      end
    join

    // Reset while BUSY: everything clears immediately, no ack.
    stall = 1;
    @(negedge CLK);
    wr0 = 1'b0; addr0 = 8'h03; req0 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK);
      #1;
      if (Start_Sig != 2'b00) break;
    end
    chk("rst_test_started", Start_Sig != 2'b00, 1);
    @(negedge CLK);
    RSTn = 1'b0;
    req0 = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge CLK);
    chk_all_zero("midreset_hold");
    stall = 0;
    RSTn = 1'b1;

    // Tie after reset goes to port 0, then continuous requests alternate.
    ack_log.delete();
    fork
      for (int i = 0; i < 3; i++) do_txn(0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) do_txn(1, 1'(i), 8'(8'h10 + i), 8'(8'hA0 + i));
    join
    chk("alt_count", ack_log.size(), 6);
    for (int i = 0; i < ack_log.size() && i < 6; i++) chk("alt_order", ack_log[i], i % 2);

    // Randomized traffic from both ports, with stray Done pulses outside BUSY.
    spur_en = 1;
    fork
      rand_port(0, 25);
      rand_port(1, 25);
    join
    spur_en = 0;

    repeat (WR_WAIT + 10) @(negedge CLK);
    chk("grant_queue_empty", gq.size(), 0);
    chk("ack_queue_empty", aq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(60000 * 10);
    failures++;
    $display("FAIL watchdog: simulation still running at cyc=%0d, required completion earlier", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eeprom_arbiter.md
Name: eeprom_arbiter

Overview:
- Shares one I2C EEPROM controller (iic_com) between two requesters, e.g. a config loader and a debug/logging port.
- Grants requests round-robin, drives the controller's start/address/data inputs, and returns per-port read data with a completion pulse.
- After every write it enforces the EEPROM internal write-cycle gap before the next transaction.
- Sits between user logic and iic_com in the EEPROM subsystem, clocked by the 50 MHz system clock.

Parameters:
- WR_WAIT, 250000, idle cycles after a write completes before the next grant (5 ms at 50 MHz); legal range 1..2^20-1.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RSTn  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held high with wr0/addr0/wdata0 stable until ack0.
- wr0  in  1  1 = write, 0 = read.
- addr0  in  8  EEPROM byte address.
- wdata0  in  8  write data.
- ack0  out  1  one-cycle completion pulse.
- rdata0  out  8  read result; valid when ack0=1, held until the next port-0 read completes.
- req1, wr1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- busy  out  1  high in every state except IDLE.
- Start_Sig  out  2  to iic_com: 2'b01 write, 2'b10 read, 2'b00 idle.
- Addr_Sig  out  8  to iic_com.
- WrData  out  8  to iic_com.
- RdData  in  8  from iic_com.
- Done_Sig  in  1  from iic_com; completion strobe.

Behaviour:
- Reset values: Start_Sig=00, Addr_Sig=00, WrData=00, ack0/1=0, rdata0/1=00, busy=0, state=IDLE, wait counter=0, last-served pointer=1 (port 0 wins the first tie).
- All outputs are registered.
- FSM states: IDLE, BUSY, RELEASE, WAIT.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port that is not the last-served one.
  - On grant, latch the port's wr/addr/wdata into Addr_Sig/WrData, set Start_Sig to 01 (wr=1) or 10 (wr=0), update the last-served pointer, and go to BUSY.
  - Latency from req to Start_Sig is 1 cycle.
- BUSY:
  - Hold Start_Sig, Addr_Sig and WrData constant.
  - Request inputs are ignored, so changes to the granted port's fields have no effect.
  - On Done_Sig=1, go to RELEASE. For a read, capture RdData into the granted port's rdata register in the same cycle.
- RELEASE (exactly 1 cycle):
  - Start_Sig=00.
  - Granted port's ack=1 for exactly this cycle.
  - Next state: WAIT if the transaction was a write, else IDLE.
- WAIT:
  - Start_Sig=00.
  - Counter counts up from 0 and exits to IDLE when it reaches WR_WAIT-1, i.e. exactly WR_WAIT cycles in WAIT.
  - Requests arriving during WAIT stay pending and are arbitrated in IDLE.
- Requester rule: req must be low at the clock edge that follows the ack cycle. The arbiter is in RELEASE, WAIT or IDLE at that point and samples req no earlier than that edge, so there is no double grant.
- Minimum gap: Start_Sig=00 for at least 2 cycles (RELEASE plus IDLE) between consecutive transactions.
- Boundary cases:
  - Done_Sig while in IDLE or WAIT is ignored.
  - A port requests again immediately after its own ack: it is served only if the other port is not requesting.
  - Both ports request continuously: grants alternate 0,1,0,1.
- Asynchronous reset mid-transaction returns all state and outputs to reset values immediately. Start_Sig drops to 00 and no ack is issued; iic_com is reset by the same RSTn.
- Write data is never modified. No timeout is implemented; a stalled Done_Sig holds BUSY indefinitely.

Test Plan:
- Single write: req0=1, wr0=1, addr0=0x00, wdata0=0x12 -> Start_Sig=01, Addr_Sig=0x00, WrData=0x12 one cycle later; Done_Sig pulse -> ack0 one cycle later; busy stays high for WR_WAIT cycles (set WR_WAIT=16 in the bench), then IDLE.
- Read back: req1, wr1=0, addr1=0x00, model returns RdData=0x12 -> Start_Sig=10; ack1 with rdata1=0x12; no WAIT phase (busy low 1 cycle after RELEASE); rdata1 still 0x12 later.
- Simultaneous requests after reset: both req high in the same cycle -> port 0 served first, port 1 next; continuous requests -> grant order 0,1,0,1.
- Request during WAIT: req0 rises 3 cycles into a 16-cycle WAIT -> Start_Sig stays 00 until WAIT expires, then port 0 is granted; Start_Sig is 00 for at least 2 cycles between transactions.
- Field change while BUSY: addr0 changes 0x05→0x09 mid-transaction -> Addr_Sig stays 0x05 until RELEASE.
- Reset mid-BUSY: assert RSTn=0 before Done_Sig -> all outputs 00/0 at once, no ack; after release the first tie goes to port 0.
